// File: rtl/grf_dual_wr_sb.sv
// grf_dual_wr_sb
//   General register file for the dual-issue datapath. Two asynchronous read
//   ports and two synchronous write ports. Register 0 always reads as zero.
//   A per-register busy scoreboard is set when an instruction with that
//   destination issues and cleared when it writes back. The hazard unit reads
//   the scoreboard to stall on pending producers.
//
// Parameters
//   DATA_W  register width
//   NREGS   number of registers including r0 (ADDR_W = $clog2(NREGS))
//   BYPASS  1: reads see same-cycle write data, 0: reads see pre-edge contents
//   TRACE   1: simulation print of every committed write
//
// Ports
//   Clk, Rst_n                 rising-edge clock, async active-low reset
//   RAddrA/B -> RDataA/B       combinational read data
//   RBusyA/B                   combinational busy bit for the read address
//   WEn0/WAddr0/WData0/WPC0    write port 0 (older instruction)
//   WEn1/WAddr1/WData1/WPC1    write port 1 (younger instruction, wins ties)
//   IssueEn/IssueAddr          destination of the instruction issued this cycle
//   WConflict                  registered pulse: last cycle both ports hit the same reg
module grf_dual_wr_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    parameter bit TRACE  = 1'b1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] RAddrA,
    input  logic [ADDR_W-1:0] RAddrB,
    output logic [DATA_W-1:0] RDataA,
    output logic [DATA_W-1:0] RDataB,
    output logic              RBusyA,
    output logic              RBusyB,
    input  logic              WEn0,
    input  logic [ADDR_W-1:0] WAddr0,
    input  logic [DATA_W-1:0] WData0,
    input  logic [31:0]       WPC0,
    input  logic              WEn1,
    input  logic [ADDR_W-1:0] WAddr1,
    input  logic [DATA_W-1:0] WData1,
    input  logic [31:0]       WPC1,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              WConflict
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;

    logic wValid0;
    logic wValid1;
    logic wCommit0;
    logic issueValid;
    logic sameAddr;

    // An address is writable/readable only if it is not r0 and exists in the
    // array; this also covers the unused top of a non-power-of-2 address space.
    function automatic logic addrOk(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && (32'(addr) < NREGS);
    endfunction

    // Qualified write/issue strobes. Port 0 is dropped when port 1 targets the
    // same register, since the younger instruction's result must survive.
    always_comb begin
        wValid0    = WEn0 && addrOk(WAddr0);
        wValid1    = WEn1 && addrOk(WAddr1);
        issueValid = IssueEn && addrOk(IssueAddr);
        sameAddr   = (WAddr0 == WAddr1);
        wCommit0   = wValid0 && !(wValid1 && sameAddr);
    end

    // Register array. r0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wCommit0) begin
                regs[WAddr0] <= WData0;
            end
            if (wValid1) begin
                regs[WAddr1] <= WData1;
            end
        end
    end

    // Scoreboard next state: writebacks clear, then issue sets, so a register
    // issued and written back in the same cycle stays busy for the new producer.
    always_comb begin
        busyNext = busy;
        if (wValid0) begin
            busyNext[WAddr0] = 1'b0;
        end
        if (wValid1) begin
            busyNext[WAddr1] = 1'b0;
        end
        if (issueValid) begin
            busyNext[IssueAddr] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Scoreboard and conflict flag state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy      <= '0;
            WConflict <= 1'b0;
        end else begin
            busy      <= busyNext;
            WConflict <= wValid0 && wValid1 && sameAddr;
        end
    end

    function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = '0;
        if (addrOk(addr)) begin
            if (BYPASS && wValid1 && (WAddr1 == addr)) begin
                value = WData1;
            end else if (BYPASS && wValid0 && (WAddr0 == addr)) begin
                value = WData0;
            end else begin
                value = regs[addr];
            end
        end
        return value;
    endfunction

    // With bypass, a same-cycle writeback already delivers the value, so the
    // reader must not stall on it; an issue only matters from the next cycle.
    function automatic logic readBusy(input logic [ADDR_W-1:0] addr);
        logic value;
        value = 1'b0;
        if (addrOk(addr)) begin
            if (BYPASS && ((wValid0 && (WAddr0 == addr)) || (wValid1 && (WAddr1 == addr)))) begin
                value = 1'b0;
            end else begin
                value = busy[addr];
            end
        end
        return value;
    endfunction

    // Combinational read ports.
    always_comb begin
        RDataA = readData(RAddrA);
        RDataB = readData(RAddrB);
        RBusyA = readBusy(RAddrA);
        RBusyB = readBusy(RAddrB);
    end

`ifndef SYNTHESIS
    // Commit trace in program order: port 0 first, dropped port-0 writes and
    // r0 writes are not shown.
    always @(posedge Clk) begin
        if (TRACE && Rst_n) begin
            if (wCommit0) begin
                $display("@%h: $%d <= %h", WPC0, WAddr0, WData0);
            end
            if (wValid1) begin
                $display("@%h: $%d <= %h", WPC1, WAddr1, WData1);
            end
        end
    end
`endif

endmodule
